rc522_reg_ctrl: RTL and testbench

//  Register-access sequencer for the RC522 RFID reader. Sits between the tag logic and the SPI byte engine.

---
 rtl/rc522_reg_ctrl_pkg.sv | 52 +++++
 rtl/rc522_reg_ctrl_if.sv | 30 +++
 rtl/rc522_reg_ctrl_init_rom.sv | 23 ++
 rtl/rc522_reg_ctrl.sv | 149 ++++++++++++++
 tb/tb_rc522_reg_ctrl.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rc522_reg_ctrl_pkg.sv
// Shared constants, types and byte-builder helpers for the RC522 register sequencer.
// Register map subset plus the FSM state encoding used by the controller.
package rc522_reg_ctrl_pkg;

  localparam int DEF_TIMEOUT_CYC = 64;
  localparam int DEF_GAP_CYC     = 2;
  localparam int DEF_INIT_LEN    = 4;

  localparam logic [5:0] COMMAND_REG      = 6'h01;
  localparam logic [5:0] COM_IRQ_REG      = 6'h04;
  localparam logic [5:0] ERROR_REG        = 6'h06;
  localparam logic [5:0] FIFO_DATA_REG    = 6'h09;
  localparam logic [5:0] FIFO_LEVEL_REG   = 6'h0A;
  localparam logic [5:0] BIT_FRAMING_REG  = 6'h0D;
  localparam logic [5:0] MODE_REG         = 6'h11;
  localparam logic [5:0] TX_CONTROL_REG   = 6'h14;
  localparam logic [5:0] TX_ASK_REG       = 6'h15;
  localparam logic [5:0] T_MODE_REG       = 6'h2A;
  localparam logic [5:0] T_PRESCALER_REG  = 6'h2B;
  localparam logic [5:0] VERSION_REG      = 6'h37;

  localparam logic [7:0] CMD_SOFT_RESET   = 8'h0F;
  localparam logic [7:0] T_MODE_INIT      = 8'h8D;
  localparam logic [7:0] T_PRESCALER_INIT = 8'h3E;
  localparam logic [7:0] TX_CONTROL_ON    = 8'h83;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_A_GO,
    ST_A_WAIT,
    ST_GAP,
    ST_D_GO,
    ST_D_WAIT,
    ST_FIN
  } state_t;

  typedef struct packed {
    logic [5:0] addr;
    logic [7:0] data;
  } rom_entry_t;

  // RC522 SPI address byte: MSB selects read, LSB is always zero.
  function automatic logic [7:0] rd_byte(input logic [5:0] addr);
    return {1'b1, addr, 1'b0};
  endfunction

  function automatic logic [7:0] wr_byte(input logic [5:0] addr);
    return {1'b0, addr, 1'b0};
  endfunction

endpackage

// File: rtl/rc522_reg_ctrl_if.sv
// Host request/response and SPI byte-engine signals of the register sequencer.
// slave = controller view, master = host plus byte-engine view.
interface rc522_reg_ctrl_if;
  logic       host_req;
  logic       host_we;
  logic [5:0] host_addr;
  logic [7:0] host_wdata;
  logic       host_ready;
  logic [7:0] host_rdata;
  logic       host_done;
  logic       host_err;
  logic       init_done;
  logic       init_fail;
  logic       spi_start;
  logic [7:0] spi_tx;
  logic [7:0] spi_rx;
  logic       spi_done;

  modport slave (
    input  host_req, host_we, host_addr, host_wdata, spi_rx, spi_done,
    output host_ready, host_rdata, host_done, host_err, init_done, init_fail,
           spi_start, spi_tx
  );

  modport master (
    output host_req, host_we, host_addr, host_wdata, spi_rx, spi_done,
    input  host_ready, host_rdata, host_done, host_err, init_done, init_fail,
           spi_start, spi_tx
  );
endinterface

// File: rtl/rc522_reg_ctrl_init_rom.sv
// Power-up write list replayed after every reset: soft reset, timer setup, antenna on.
// Purely combinational; out-of-range indices return zero.
module rc522_reg_ctrl_init_rom
  import rc522_reg_ctrl_pkg::*;
#(
  parameter int IDX_W = 3
) (
  input  logic [IDX_W-1:0] idx,
  output rom_entry_t       entry
);

  always_comb begin
    entry = '0;
    case (int'(idx))
      0:       entry = '{addr: COMMAND_REG,     data: CMD_SOFT_RESET};
      1:       entry = '{addr: T_MODE_REG,      data: T_MODE_INIT};
      2:       entry = '{addr: T_PRESCALER_REG, data: T_PRESCALER_INIT};
      3:       entry = '{addr: TX_CONTROL_REG,  data: TX_CONTROL_ON};
      default: entry = '0;
    endcase
  end

endmodule

// File: rtl/rc522_reg_ctrl.sv
// RC522 register-access sequencer: init list replay, then host reads/writes as
// address+data SPI byte pairs, each byte guarded by a shared timeout counter.
module rc522_reg_ctrl
  import rc522_reg_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int GAP_CYC     = DEF_GAP_CYC,
  parameter int INIT_LEN    = DEF_INIT_LEN
) (
  input  logic              clk,
  input  logic              rst,
  rc522_reg_ctrl_if.slave   bus
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam int IDX_W = $clog2(INIT_LEN + 1);

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] idx;
  logic [TMR_W-1:0] tmr;
  logic             done_q;
  logic             cap_we;
  logic [5:0]       cap_addr;
  logic [7:0]       cap_wdata;
  logic             err_q;
  logic [7:0]       rdata_q;
  logic             init_done_q;
  logic             init_fail_q;
  rom_entry_t       rom_entry;

  logic             done_edge;
  logic             timeout;
  logic             init_end;
  logic             gap_end;
  logic             tmr_clr;
  logic [7:0]       addr_byte;
  logic [7:0]       data_byte;

  rc522_reg_ctrl_init_rom #(.IDX_W(IDX_W)) u_init_rom (
    .idx   (idx),
    .entry (rom_entry)
  );

  // The engine holds done high until the next start, so only its rising edge counts.
  assign done_edge = bus.spi_done & ~done_q;
  assign timeout   = (tmr == TMR_W'(TIMEOUT_CYC - 1)) & ~done_edge;
  assign init_end  = (idx == IDX_W'(INIT_LEN));
  assign gap_end   = (tmr == TMR_W'(GAP_CYC - 1));

  assign addr_byte = cap_we ? wr_byte(cap_addr) : rd_byte(cap_addr);
  assign data_byte = cap_we ? cap_wdata : 8'h00;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT:   state_nxt = init_end ? ST_IDLE : ST_A_GO;
      ST_IDLE:   if (bus.host_req) state_nxt = ST_A_GO;
      ST_A_GO:   state_nxt = ST_A_WAIT;
      ST_A_WAIT: begin
        if (done_edge)    state_nxt = ST_GAP;
        else if (timeout) state_nxt = ST_FIN;
      end
      ST_GAP:    if (gap_end) state_nxt = ST_D_GO;
      ST_D_GO:   state_nxt = ST_D_WAIT;
      ST_D_WAIT: if (done_edge || timeout) state_nxt = ST_FIN;
      // An init-phase timeout abandons the rest of the list.
      ST_FIN:    state_nxt = (!init_done_q && !err_q) ? ST_INIT : ST_IDLE;
      default:   state_nxt = ST_INIT;
    endcase
  end

  // One timer serves both the per-byte timeout and the inter-byte gap.
  assign tmr_clr = (state_nxt != state) &&
                   (state_nxt inside {ST_A_GO, ST_D_GO, ST_GAP});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_INIT;
      idx         <= '0;
      tmr         <= '0;
      done_q      <= 1'b0;
      cap_we      <= 1'b0;
      cap_addr    <= '0;
      cap_wdata   <= '0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      init_done_q <= 1'b0;
      init_fail_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= bus.spi_done;

      if (tmr_clr)        tmr <= '0;
      else if (tmr != '1) tmr <= tmr + TMR_W'(1);

      case (state)
        ST_INIT: begin
          if (init_end) begin
            init_done_q <= 1'b1;
          end else begin
            cap_we    <= 1'b1;
            cap_addr  <= rom_entry.addr;
            cap_wdata <= rom_entry.data;
            err_q     <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (bus.host_req) begin
            cap_we    <= bus.host_we;
            cap_addr  <= bus.host_addr;
            cap_wdata <= bus.host_wdata;
            err_q     <= 1'b0;
          end
        end
        ST_A_WAIT: if (timeout) err_q <= 1'b1;
        ST_D_WAIT: begin
          // Latch read data on the edge so it is already valid while host_done pulses.
          if (done_edge) begin
            if (!cap_we && init_done_q) rdata_q <= bus.spi_rx;
          end else if (timeout) begin
            err_q <= 1'b1;
          end
        end
        ST_FIN: begin
          if (!init_done_q) begin
            if (err_q) begin
              init_fail_q <= 1'b1;
              init_done_q <= 1'b1;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.host_ready = (state == ST_IDLE);
  assign bus.host_done  = (state == ST_FIN) && init_done_q;
  assign bus.host_err   = (state == ST_FIN) && init_done_q && err_q;
  assign bus.host_rdata = rdata_q;
  assign bus.init_done  = init_done_q;
  assign bus.init_fail  = init_fail_q;
  assign bus.spi_start  = (state == ST_A_GO) || (state == ST_D_GO);
  assign bus.spi_tx     = (state inside {ST_A_GO, ST_A_WAIT}) ? addr_byte : data_byte;

endmodule

// File: tb/tb_rc522_reg_ctrl.sv
// Scoreboard bench for rc522_reg_ctrl: byte-engine model, directed host traffic,
// expected SPI bytes and host completions queued by stimulus and popped by a monitor.
module tb_rc522_reg_ctrl;

  typedef struct {
    logic       err;
    logic       chk_rdata;
    logic [7:0] rdata;
  } host_exp_t;

  logic clk;
  logic rst;
  rc522_reg_ctrl_if bus();

  rc522_reg_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cnt = 0;
  int done_cnt = 0;
  int start_cyc = 0;
  int done_cyc = 0;

  logic [7:0] exp_tx[$];
  host_exp_t  exp_host[$];
  logic [7:0] tx_pop;
  host_exp_t  host_pop;

  // Byte-engine model state
  int         hang_at = 0;
  int         start_num = 0;
  logic       force_rx = 1'b0;
  logic [7:0] rx_val = 8'h00;
  logic       bfm_busy;
  int         bfm_cnt;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Done level rises 10 cycles after the start pulse; RX = TX ^ FF unless forced.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.spi_done <= 1'b0;
      bus.spi_rx   <= 8'h00;
      bfm_busy     <= 1'b0;
      bfm_cnt      <= 0;
      start_num    <= 0;
    end else if (bus.spi_start) begin
      start_num    <= start_num + 1;
      bus.spi_done <= 1'b0;
      bfm_busy     <= (start_num + 1 != hang_at);
      bfm_cnt      <= 0;
      bus.spi_rx   <= force_rx ? rx_val : (bus.spi_tx ^ 8'hFF);
    end else if (bfm_busy) begin
      bfm_cnt <= bfm_cnt + 1;
      if (bfm_cnt == 8) begin
        bus.spi_done <= 1'b1;
        bfm_busy     <= 1'b0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT starts a byte or completes a request.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.spi_start) begin
        start_cnt++;
        start_cyc = cyc;
        if (exp_tx.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spi_start_extra: got start with tx 0x%02h, expected no start", bus.spi_tx);
        end else begin
          tx_pop = exp_tx.pop_front();
          check("spi_tx", int'(bus.spi_tx), int'(tx_pop));
        end
      end
      if (bus.host_done) begin
        done_cnt++;
        done_cyc = cyc;
        if (exp_host.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL host_done_extra: got host_done err=%0b, expected none", bus.host_err);
        end else begin
          host_pop = exp_host.pop_front();
          check("host_err", int'(bus.host_err), int'(host_pop.err));
          if (host_pop.chk_rdata) check("host_rdata", int'(bus.host_rdata), int'(host_pop.rdata));
        end
      end
      if (bus.host_err && !bus.host_done) begin
        checks++;
        errors++;
        $display("FAIL host_err_alone: got host_err=1 with host_done=0, expected coincident");
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_init_done(input int budget);
    int n = 0;
    while (!bus.init_done && n < budget) begin @(negedge clk); n++; end
    check("init_done_wait", int'(bus.init_done), 1);
  endtask

  task automatic wait_ready(input int budget);
    int n = 0;
    while (!bus.host_ready && n < budget) begin @(negedge clk); n++; end
    check("host_ready_wait", int'(bus.host_ready), 1);
  endtask

  task automatic wait_dones(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin @(negedge clk); n++; end
    check("host_done_wait", done_cnt, target);
  endtask

  task automatic wait_starts(input int target, input int budget);
    int n = 0;
    while (start_cnt < target && n < budget) begin @(negedge clk); n++; end
    check("spi_start_wait", start_cnt, target);
  endtask

  task automatic check_reset_outputs();
    check("rst_host_ready", int'(bus.host_ready), 0);
    check("rst_host_done",  int'(bus.host_done),  0);
    check("rst_host_err",   int'(bus.host_err),   0);
    check("rst_init_done",  int'(bus.init_done),  0);
    check("rst_init_fail",  int'(bus.init_fail),  0);
    check("rst_spi_start",  int'(bus.spi_start),  0);
    check("rst_spi_tx",     int'(bus.spi_tx),     0);
    check("rst_host_rdata", int'(bus.host_rdata), 0);
  endtask

  task automatic push_init_list();
    logic [7:0] init_bytes[8] = '{8'h02, 8'h0F, 8'h54, 8'h8D, 8'h56, 8'h3E, 8'h28, 8'h83};
    foreach (init_bytes[i]) exp_tx.push_back(init_bytes[i]);
  endtask

  task automatic issue(input logic we, input logic [5:0] addr, input logic [7:0] wdata);
    wait_ready(400);
    bus.host_req   = 1'b1;
    bus.host_we    = we;
    bus.host_addr  = addr;
    bus.host_wdata = wdata;
    @(negedge clk);
    bus.host_req   = 1'b0;
  endtask

  task automatic push_host(input logic err, input logic chk, input logic [7:0] rdata);
    host_exp_t e;
    e.err = err;
    e.chk_rdata = chk;
    e.rdata = rdata;
    exp_host.push_back(e);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bus.host_req   = 1'b0;
    bus.host_we    = 1'b0;
    bus.host_addr  = 6'h00;
    bus.host_wdata = 8'h00;
    rst = 1'b1;
    tick(3);
    check_reset_outputs();

    // Power-up init replay
    push_init_list();
    base = start_cnt;
    rst = 1'b0;
    wait_init_done(1000);
    check("init_fail_clean", int'(bus.init_fail), 0);
    check("init_ready", int'(bus.host_ready), 1);
    check("init_start_count", start_cnt - base, 8);

    // Host write 0x24 <- 0x5A
    exp_tx.push_back(8'h48);
    exp_tx.push_back(8'h5A);
    push_host(1'b0, 1'b0, 8'h00);
    issue(1'b1, 6'h24, 8'h5A);
    wait_dones(1, 400);

    // Host read 0x37, engine returns 0x92 on the data byte
    force_rx = 1'b1;
    rx_val   = 8'h92;
    exp_tx.push_back(8'hEE);
    exp_tx.push_back(8'h00);
    push_host(1'b0, 1'b1, 8'h92);
    issue(1'b0, 6'h37, 8'h00);
    wait_dones(2, 400);
    force_rx = 1'b0;
    tick(2);
    check("rdata_hold", int'(bus.host_rdata), 8'h92);

    // Address byte never completes: timeout, no data byte, rdata unchanged
    wait_ready(100);
    hang_at = start_num + 1;
    exp_tx.push_back(8'hA0);
    push_host(1'b1, 1'b1, 8'h92);
    base = start_cnt;
    issue(1'b0, 6'h10, 8'h00);
    wait_dones(3, 400);
    check("timeout_latency", done_cyc - start_cyc, 64);
    tick(30);
    check("timeout_single_start", start_cnt - base, 1);
    hang_at = 0;

    // Request while busy is ignored; reset lands in the data-byte wait
    exp_tx.push_back(8'h0A);
    exp_tx.push_back(8'h11);
    base = start_cnt;
    issue(1'b1, 6'h05, 8'h11);
    wait_starts(base + 1, 50);
    bus.host_req   = 1'b1;
    bus.host_we    = 1'b1;
    bus.host_addr  = 6'h3F;
    bus.host_wdata = 8'hAA;
    tick(5);
    bus.host_req = 1'b0;
    wait_starts(base + 2, 100);
    tick(3);
    check("busy_req_ignored", start_cnt - base, 2);
    rst = 1'b1;
    tick(1);
    check_reset_outputs();
    push_init_list();
    base = start_cnt;
    tick(2);
    rst = 1'b0;
    wait_init_done(1000);
    check("replay_start_count", start_cnt - base, 8);
    check("replay_init_fail", int'(bus.init_fail), 0);

    // Engine hangs on the second init entry's address byte
    rst = 1'b1;
    tick(2);
    hang_at = 3;
    exp_tx.push_back(8'h02);
    exp_tx.push_back(8'h0F);
    exp_tx.push_back(8'h54);
    base = start_cnt;
    rst = 1'b0;
    wait_init_done(1000);
    check("hang_init_fail", int'(bus.init_fail), 1);
    check("hang_ready", int'(bus.host_ready), 1);
    tick(20);
    check("hang_start_count", start_cnt - base, 3);
    hang_at = 0;

    // Host traffic still works after an aborted init
    exp_tx.push_back(8'h7E);
    exp_tx.push_back(8'hC3);
    push_host(1'b0, 1'b0, 8'h00);
    issue(1'b1, 6'h3F, 8'hC3);
    wait_dones(4, 400);
    tick(5);

    check("exp_tx_drained", exp_tx.size(), 0);
    check("exp_host_drained", exp_host.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
